// File: rtl/sap1_pkg.sv
// sap1_pkg: opcodes, control-word bit positions and microcode words for the SAP-1 controller.
package sap1_pkg;
  typedef logic [11:0] con_t;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int CP = 11;
  localparam int EP = 10;
  localparam int LM_BAR = 9;
  localparam int CE_BAR = 8;
  localparam int LI_BAR = 7;
  localparam int EI_BAR = 6;
  localparam int LA_BAR = 5;
  localparam int EA = 4;
  localparam int SU = 3;
  localparam int EU = 2;
  localparam int LB_BAR = 1;
  localparam int LO_BAR = 0;
  function automatic con_t bit_of(input int b);
    bit_of = '0;
    bit_of[b] = 1'b1;
  endfunction
  // Every word starts from NOP: active-low controls are asserted by clearing their bit.
  localparam con_t CON_NOP = bit_of(LM_BAR) | bit_of(CE_BAR) | bit_of(LI_BAR) | bit_of(EI_BAR)
                           | bit_of(LA_BAR) | bit_of(LB_BAR) | bit_of(LO_BAR);
  localparam con_t CON_T1 = (CON_NOP | bit_of(EP)) & ~bit_of(LM_BAR);
  localparam con_t CON_T2 = CON_NOP | bit_of(CP);
  localparam con_t CON_T3 = CON_NOP & ~bit_of(CE_BAR) & ~bit_of(LI_BAR);
  localparam con_t CON_IR_ADDR = CON_NOP & ~bit_of(LM_BAR) & ~bit_of(EI_BAR);
  localparam con_t CON_LDA_T5 = CON_NOP & ~bit_of(CE_BAR) & ~bit_of(LA_BAR);
  localparam con_t CON_ALU_T5 = CON_NOP & ~bit_of(CE_BAR) & ~bit_of(LB_BAR);
  localparam con_t CON_ADD_T6 = (CON_NOP | bit_of(EU)) & ~bit_of(LA_BAR);
  localparam con_t CON_SUB_T6 = CON_ADD_T6 | bit_of(SU);
  localparam con_t CON_OUT_T4 = (CON_NOP | bit_of(EA)) & ~bit_of(LO_BAR);
  function automatic con_t exec_word(input logic [1:0] step, input logic [3:0] op);
    case (op)
      OP_LDA: exec_word = step == 2'd0 ? CON_IR_ADDR : step == 2'd1 ? CON_LDA_T5 : CON_NOP;
      OP_ADD: exec_word = step == 2'd0 ? CON_IR_ADDR : step == 2'd1 ? CON_ALU_T5 : CON_ADD_T6;
      OP_SUB: exec_word = step == 2'd0 ? CON_IR_ADDR : step == 2'd1 ? CON_ALU_T5 : CON_SUB_T6;
      OP_OUT: exec_word = step == 2'd0 ? CON_OUT_T4 : CON_NOP;
      default: exec_word = CON_NOP;
    endcase
  endfunction
endpackage

// File: rtl/sap1_tstate_monitor.sv
// sap1_tstate_monitor: checks the ring counter's one-hot stream and flags the T[STATES]->T1 wrap.
module sap1_tstate_monitor
  import sap1_pkg::*;
#(
  parameter int STATES = 6
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic [STATES-1:0] state,
  output logic              err,
  output logic              wrap
);
  localparam logic [STATES-1:0] T1 = STATES'(1);
  logic [STATES-1:0] prev_state;
  logic bad;
  always_comb begin
    bad = !$onehot(state) || (state != prev_state && state != {prev_state[STATES-2:0], prev_state[STATES-1]});
    wrap = prev_state[STATES-1] && state == T1 && !bad;
  end
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      prev_state <= T1;
      err <= 1'b0;
    end else begin
      prev_state <= state;
      err <= err | bad;
    end
  end
endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: decodes T-state and opcode into the SAP-1 control word; tracks halt and instruction count.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int STATES = 6
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic [STATES-1:0] state,
  input  logic [3:0]        opcode,
  output logic [11:0]       con,
  output logic              hlt,
  output logic              err,
  output logic [7:0]        icount
);
  logic wrap;
  con_t word;
  sap1_tstate_monitor #(.STATES(STATES)) u_mon (
    .CLK(CLK),
    .CLR_bar(CLR_bar),
    .state(state),
    .err(err),
    .wrap(wrap)
  );
  always_comb begin
    word = state[0] ? CON_T1 : state[1] ? CON_T2 : state[2] ? CON_T3 :
           state[3] ? exec_word(2'd0, opcode) : state[4] ? exec_word(2'd1, opcode) :
           state[5] ? exec_word(2'd2, opcode) : CON_NOP;
    con = (!CLR_bar || hlt || err || !$onehot(state)) ? CON_NOP : word;
  end
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      hlt <= 1'b0;
      icount <= 8'd0;
    end else begin
      hlt <= hlt | (state == STATES'(8) && opcode == OP_HLT);
      if (wrap && !hlt && !err) icount <= icount + 8'd1;
    end
  end
endmodule
